// File: rtl/mdu_iter.sv
// Iterative multiply/divide core: shift-add multiply and restoring divide, one bit per cycle.
// Produces the GPR result plus the flag word D = {OV, LT, GT, EQ} for the data-out stage.
module mdu_iter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       Op,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [0:WIDTH-1] result,
  output logic [0:3]       D
);

  localparam int unsigned PW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MULLW  = 3'b000;
  localparam logic [2:0] OP_MULHW  = 3'b001;
  localparam logic [2:0] OP_MULHWU = 3'b010;
  localparam logic [2:0] OP_DIVW   = 3'b100;
  localparam logic [2:0] OP_DIVWU  = 3'b101;

  logic [1:0]           r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_op;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_opnd;   // multiplicand or divisor magnitude
  logic [PW-1:0]        r_acc;    // {partial product | multiplier} or {remainder | quotient}
  logic [WIDTH-1:0]     r_result;
  logic [3:0]           r_d;

  logic [WIDTH-1:0] w_a, w_b, w_mag_a, w_mag_b, w_div_sub, w_fin_res;
  logic             w_is_mul, w_is_div, w_signed, w_neg_a, w_neg_b, w_div_special;
  logic             w_accept, w_div_ge, w_fin_ov;
  logic [WIDTH:0]   w_mul_sum, w_div_shift;
  logic [PW-1:0]    w_mul_next, w_div_next, w_iter, w_prod_s;
  logic [WIDTH:0]   w_hi_sign;

  always_comb begin
    w_a           = A;
    w_b           = B;
    w_is_mul      = (Op == OP_MULLW) || (Op == OP_MULHW) || (Op == OP_MULHWU);
    w_is_div      = (Op == OP_DIVW) || (Op == OP_DIVWU);
    w_signed      = (Op == OP_MULLW) || (Op == OP_MULHW) || (Op == OP_DIVW);
    w_neg_a       = w_signed && w_a[WIDTH-1];
    w_neg_b       = w_signed && w_b[WIDTH-1];
    w_mag_a       = w_neg_a ? -w_a : w_a;
    w_mag_b       = w_neg_b ? -w_b : w_b;
    w_div_special = w_is_div && ((w_b == '0) ||
                    ((Op == OP_DIVW) && (w_a == {1'b1, {(WIDTH-1){1'b0}}}) && (w_b == '1)));
    w_accept      = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    w_mul_sum  = {1'b0, r_acc[PW-1:WIDTH]} + {1'b0, r_opnd};
    w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[PW-1:1]};

    // Low-bit subtraction suffices: when the divisor fits, the remainder is below 2^WIDTH.
    w_div_shift = {r_acc[PW-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge    = w_div_shift >= {1'b0, r_opnd};
    w_div_sub   = w_div_shift[WIDTH-1:0] - r_opnd;
    w_div_next  = w_div_ge ? {w_div_sub, r_acc[WIDTH-2:0], 1'b1}
                           : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    w_iter    = (r_state == S_MUL) ? w_mul_next : w_div_next;
    w_prod_s  = r_neg ? -w_iter : w_iter;
    w_hi_sign = w_prod_s[PW-1:WIDTH-1];

    w_fin_res = w_prod_s[WIDTH-1:0];
    w_fin_ov  = 1'b0;
    if (r_op == OP_MULLW) begin
      w_fin_ov = !((&w_hi_sign) || !(|w_hi_sign));
    end else if ((r_op == OP_MULHW) || (r_op == OP_MULHWU)) begin
      w_fin_res = w_prod_s[PW-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg    <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_d      <= '0;
    end else if (flush && (r_state != S_IDLE)) begin
      r_state <= S_IDLE;
    end else if (w_accept) begin
      r_op     <= Op;
      r_neg    <= w_neg_a ^ w_neg_b;
      r_cnt    <= '0;
      r_result <= '0;
      if (w_is_mul) begin
        r_state <= S_MUL;
        r_opnd  <= w_mag_a;
        r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
        r_d     <= 4'b0000;
      end else if (w_div_special) begin
        r_state <= S_DONE;
        r_d     <= 4'b1001;
      end else if (w_is_div) begin
        r_state <= S_DIV;
        r_opnd  <= w_mag_b;
        r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
        r_d     <= 4'b0000;
      end else begin
        r_state <= S_DONE;
        r_d     <= 4'b0001;
      end
    end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
      r_acc <= w_iter;
      r_cnt <= r_cnt + CNT_WIDTH'(1);
      if (r_cnt == CNT_WIDTH'(WIDTH - 1)) begin
        r_state  <= S_DONE;
        r_result <= w_fin_res;
        r_d      <= {w_fin_ov, w_fin_res[WIDTH-1], !w_fin_res[WIDTH-1] && (w_fin_res != '0),
                     w_fin_res == '0};
      end
    end else if (r_state == S_DONE) begin
      r_state <= S_IDLE;
    end
  end

  assign busy   = (r_state == S_MUL) || (r_state == S_DIV);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign D      = r_d;

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed plan cases plus random ops checked against an arithmetic model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst, start, flush, busy, done;
  logic [2:0]  Op;
  logic [0:31] A, B, result;
  logic [0:3]  D;
  int          total = 0;
  int          bad   = 0;

  mdu_iter #(.WIDTH(32), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .start(start), .Op(Op), .A(A), .B(B), .flush(flush),
    .busy(busy), .done(done), .result(result), .D(D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on the architectural operands.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic [3:0] d, output int lat);
    longint      p;
    logic [63:0] u;
    int          ia, ib;
    logic        ov;
    ov = 1'b0; res = '0; lat = 33;
    ia = a; ib = b;
    case (op)
      3'b000: begin
        p   = longint'(ia) * longint'(ib);
        res = p[31:0];
        ov  = (p != longint'($signed(res)));
      end
      3'b001: begin p = longint'(ia) * longint'(ib); res = p[63:32]; end
      3'b010: begin u = {32'b0, a} * {32'b0, b}; res = u[63:32]; end
      3'b100: begin
        if (b == 0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin ov = 1'b1; lat = 1; end
        else res = ia / ib;
      end
      3'b101: begin
        if (b == 0) begin ov = 1'b1; lat = 1; end
        else res = a / b;
      end
      default: lat = 1;
    endcase
    d = {ov, res[31], !res[31] && (res != 0), res == 0};
  endfunction

  // Drive start at a negedge; returns on the negedge after the accepting edge (cycle 1).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; Op = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; Op = 3'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] er, input logic [3:0] ed,
                           input int lat);
    int n = 1;
    bit busy_bad = 1'b0;
    while (done !== 1'b1 && n < 60) begin
      if (busy !== (n < lat)) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_busy"}, 64'(busy_bad), 64'd0);
    check({tag, "_res"}, 64'(result), 64'(er));
    check({tag, "_d"}, 64'(D), 64'(ed));
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b);
    logic [31:0] er;
    logic [3:0]  ed;
    int          lat;
    model(op, a, b, er, ed, lat);
    issue(op, a, b);
    wait_done(tag, er, ed, lat);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, 64'(result), 64'(er));
  endtask

  initial begin
    logic [31:0] er, ra, rb;
    logic [3:0]  ed;
    logic [2:0]  rop;
    int          lat;
    bit          seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; Op = '0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_res", 64'(result), 64'd0);
    check("rst_d", 64'(D), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run("mullw_neg", 3'b000, 32'd7, 32'hFFFF_FFFD);
    check("plan_mullw", 64'(result), 64'hFFFF_FFEB);
    run("mullw_ov", 3'b000, 32'h0001_0000, 32'h0001_0000);
    check("plan_mullw_ov_d", 64'(D), 64'b1001);
    run("mulhwu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mulhw", 3'b001, 32'h8000_0000, 32'h8000_0000);
    run("divw", 3'b100, 32'hFFFF_FFF9, 32'd2);
    check("plan_divw", 64'(result), 64'hFFFF_FFFD);
    run("divwu", 3'b101, 32'd100, 32'd7);
    run("divw_z", 3'b100, 32'd1234, 32'd0);
    run("divw_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    run("divwu_z", 3'b101, 32'd55, 32'd0);
    run("nop", 3'b011, 32'd5, 32'd6);

    // Flush mid-multiply: no done may follow.
    issue(3'b000, 32'd12345, 32'd678);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("flush_nodone", 64'(seen), 64'd0);
    run("after_flush", 3'b101, 32'd9, 32'd3);
    check("plan_9div3", 64'(result), 64'd3);

    // Back-to-back: issue again while done is high.
    model(3'b000, 32'hDEAD_BEEF, 32'h1234_5678, er, ed, lat);
    issue(3'b000, 32'hDEAD_BEEF, 32'h1234_5678);
    wait_done("b2b_first", er, ed, lat);
    model(3'b101, 32'hFFFF_0000, 32'd13, er, ed, lat);
    issue(3'b101, 32'hFFFF_0000, 32'd13);
    wait_done("b2b_second", er, ed, lat);
    @(negedge clk);

    // Reset mid-divide: outputs clear and no done follows.
    issue(3'b100, 32'h7654_3210, 32'd17);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_done", 64'(done), 64'd0);
    check("rstmid_res", 64'(result), 64'd0);
    check("rstmid_d", 64'(D), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    check("rstmid_nodone", 64'(seen), 64'd0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: rop = 3'b000;
        1: rop = 3'b001;
        2: rop = 3'b010;
        3: rop = 3'b100;
        4: rop = 3'b101;
        default: rop = 3'b110;
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 24);
      run($sformatf("rnd%0d", i), rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
